// File: rtl/bank_read_return_if.sv
// Bus bundle for the bank read-return path: request side, per-bank read data
// and the in-order response stream.
interface bank_read_return_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 3
);
  // Request handshake: a request transfers on a cycle where i_req_valid and
  // o_req_ready are both high; o_req_ready never depends on i_req_valid.
  // Bank data and responses are single-cycle valid pulses without backpressure.
  logic                    i_req_valid;
  logic [3:0]              i_req_bank_en;
  logic                    o_req_ready;
  logic [3:0]              i_bank_rvalid;
  logic [4*DATA_WIDTH-1:0] i_bank_rdata;
  logic                    o_rvalid;
  logic [DATA_WIDTH-1:0]   o_rdata;
  logic [1:0]              o_rbank;
  logic [CNT_WIDTH-1:0]    o_outstanding;
  logic                    o_err;

  modport slave (
    input  i_req_valid, i_req_bank_en, i_bank_rvalid, i_bank_rdata,
    output o_req_ready, o_rvalid, o_rdata, o_rbank, o_outstanding, o_err
  );

  modport master (
    output i_req_valid, i_req_bank_en, i_bank_rvalid, i_bank_rdata,
    input  o_req_ready, o_rvalid, o_rdata, o_rbank, o_outstanding, o_err
  );
endinterface

// File: rtl/bank_read_return.sv
// Read-return path for a 4-bank memory: tags requests with their bank index,
// collects out-of-order bank data and returns it strictly in request order.
module bank_read_return #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  bank_read_return_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]            fifo_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [CNT_WIDTH-1:0]  pend_q [4];
  logic [CNT_WIDTH-1:0]  pend_d [4];
  logic [3:0]            hold_v_q, hold_v_d;
  logic [DATA_WIDTH-1:0] hold_q [4];
  logic [DATA_WIDTH-1:0] hold_d [4];
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rbank_q, rbank_d;
  logic                  err_q, err_d;

  // Bank b lives at bit (3-b) of the enable/valid vectors and the (3-b) data slice.
  logic [3:0]            bank_v;
  logic [DATA_WIDTH-1:0] bank_d [4];
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      bank_v[b] = bus.i_bank_rvalid[3-b];
      bank_d[b] = bus.i_bank_rdata[(3-b)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  logic       full, req_fire, one_hot, push, bad_req, pop, nonempty;
  logic [1:0] push_idx, head;
  logic [3:0] drain, bypass;

  assign full     = (count_q == CNT_WIDTH'(DEPTH));
  assign nonempty = (count_q != '0);
  assign req_fire = bus.i_req_valid && !full;
  assign one_hot  = $onehot(bus.i_req_bank_en);
  assign push     = req_fire && one_hot;
  assign bad_req  = req_fire && !one_hot;
  assign head     = fifo_q[rd_ptr_q];
  assign pop      = nonempty && (hold_v_q[head] || bank_v[head]);

  always_comb begin
    case (bus.i_req_bank_en)
      4'b1000: push_idx = 2'd0;
      4'b0100: push_idx = 2'd1;
      4'b0010: push_idx = 2'd2;
      4'b0001: push_idx = 2'd3;
      default: push_idx = 2'd0;
    endcase
  end

  // A held entry has priority over live data when the head bank is served.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      drain[b]  = pop && (head == 2'(b)) && hold_v_q[b];
      bypass[b] = pop && (head == 2'(b)) && !hold_v_q[b];
    end
  end

  always_comb begin
    hold_v_d = hold_v_q;
    hold_d   = hold_q;
    pend_d   = pend_q;
    err_d    = bad_req;
    rvalid_d = pop;
    rdata_d  = rdata_q;
    rbank_d  = rbank_q;
    if (pop) begin
      rbank_d = head;
      rdata_d = hold_v_q[head] ? hold_q[head] : bank_d[head];
    end
    for (int b = 0; b < 4; b++) begin
      if (drain[b]) hold_v_d[b] = 1'b0;
      // Data is only kept if some request for this bank remains unserved.
      if (bank_v[b] && !bypass[b]) begin
        if ((pend_q[b] == '0) || (drain[b] && pend_q[b] == CNT_WIDTH'(1))) begin
          err_d = 1'b1;
        end else if (hold_v_q[b] && !drain[b]) begin
          err_d = 1'b1;
        end else begin
          hold_v_d[b] = 1'b1;
          hold_d[b]   = bank_d[b];
        end
      end
      if (push && push_idx == 2'(b)) pend_d[b] = pend_d[b] + CNT_WIDTH'(1);
      if (pop && head == 2'(b))      pend_d[b] = pend_d[b] - CNT_WIDTH'(1);
    end
  end

  always_comb begin
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      for (int b = 0; b < 4; b++) begin
        pend_q[b] <= '0;
        hold_q[b] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_v_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rbank_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= push_idx;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q  <= count_d;
      pend_q   <= pend_d;
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rbank_q  <= rbank_d;
      err_q    <= err_d;
    end
  end

  assign bus.o_req_ready   = !full;
  assign bus.o_rvalid      = rvalid_q;
  assign bus.o_rdata       = rdata_q;
  assign bus.o_rbank       = rbank_q;
  assign bus.o_outstanding = count_q;
  assign bus.o_err         = err_q;

endmodule
